// File: rtl/fp_mult_arbiter.sv
// Round-robin front end sharing one pipelined fp_mult among NUM_REQ requesters.
// A tag pipeline matched to the multiplier latency steers each product back to its issuer.
module fp_mult_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int LATENCY = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  mul_en,
    output logic [31:0]           mul_a,
    output logic [31:0]           mul_b,
    input  logic [31:0]           mul_q,
    output logic [NUM_REQ-1:0]    rsp_valid,
    output logic [31:0]           rsp_q,
    output logic                  idle
);
    localparam int TW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [TW-1:0]                ptr;
    logic [LATENCY-1:0]           vld_pipe;
    logic [LATENCY-1:0][TW-1:0]   tag_pipe;
    logic [NUM_REQ-1:0][31:0]     a_arr;
    logic [NUM_REQ-1:0][31:0]     b_arr;
    logic                         gnt_any;
    logic [TW-1:0]                gnt_idx;
    int                           idx;

    assign a_arr  = req_a;
    assign b_arr  = req_b;
    assign mul_en = clk_en;
    assign rsp_q  = mul_q;
    assign idle   = (req == '0) && (vld_pipe == '0);

    // Scan candidates starting at ptr; the first active request wins.
    always_comb begin
        gnt     = '0;
        gnt_any = 1'b0;
        gnt_idx = '0;
        idx     = 0;
        if (clk_en && !reset) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                idx = (int'(ptr) + k) % NUM_REQ;
                if (!gnt_any && req[idx]) begin
                    gnt_any = 1'b1;
                    gnt_idx = idx[TW-1:0];
                end
            end
            if (gnt_any) gnt[gnt_idx] = 1'b1;
        end
    end

    // Idle operands are zero so the multiplier computes a harmless 0.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        if (gnt_any) begin
            mul_a = a_arr[gnt_idx];
            mul_b = b_arr[gnt_idx];
        end
    end

    always_comb begin
        rsp_valid = '0;
        if (clk_en && !reset && vld_pipe[LATENCY-1])
            rsp_valid[tag_pipe[LATENCY-1]] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ptr      <= '0;
            vld_pipe <= '0;
            tag_pipe <= '0;
        end else if (clk_en) begin
            if (gnt_any)
                ptr <= (gnt_idx == TW'(NUM_REQ-1)) ? '0 : gnt_idx + 1'b1;
            vld_pipe[0] <= gnt_any;
            tag_pipe[0] <= gnt_idx;
            for (int s = 1; s < LATENCY; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end
endmodule

// File: doc/fp_mult_arbiter.md
# fp_mult_arbiter

Round-robin arbiter that shares one pipelined single-precision `fp_mult` instance among up to `NUM_REQ` requesters. The requesters are the function-evaluation controllers and the CORDIC argument-scaling logic. It sits between the requesters and the multiplier. Each cycle it issues at most one operand pair, tags the operation through a shadow pipeline matched to the multiplier latency, and routes each product back to the requester that issued it. This lets several evaluation engines run concurrently on one multiplier instead of each instantiating its own.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters (2..8).
- `LATENCY`, default 3: enabled clock cycles from operands presented on `mul_a`/`mul_b` to product on `mul_q`. Must equal the configured `fp_mult` latency.

Ports:
- `clk`  in  1: clock.
- `reset`  in  1: synchronous, active-high.
- `clk_en`  in  1: global enable. When low, all state freezes and no grants are issued.
- `req`  in  `NUM_REQ`: request per requester. Held with operands until granted.
- `req_a`  in  `32*NUM_REQ`: operand A, requester i at bits [32i+31:32i].
- `req_b`  in  `32*NUM_REQ`: operand B, same packing.
- `gnt`  out  `NUM_REQ`: one-hot, combinational. The operands of the granted requester are issued this cycle.
- `mul_en`  out  1: drives `fp_mult.en`. Equal to `clk_en`.
- `mul_a`, `mul_b`  out  32: multiplier operands.
- `mul_q`  in  32: multiplier product.
- `rsp_valid`  out  `NUM_REQ`: one-hot, one-cycle pulse. The product for requester i is on `rsp_q`.
- `rsp_q`  out  32: product, equal to `mul_q`.
- `idle`  out  1: high when `req` is all zero and no operation is in flight.

## Operation
- **Arbitration.** Rotating-priority round robin with pointer `ptr` (reset 0).
  - The candidate order is `ptr`, `ptr+1`, … wrapping modulo `NUM_REQ`.
  - The first requester with `req` high is granted.
  - On a grant to i with `clk_en` high, `ptr` updates to (i+1) mod `NUM_REQ`.
  - `ptr` is unchanged when nothing is granted.
- **Grant conditions.**
  - `gnt` is all zero when `clk_en` is low or `reset` is high.
  - At most one bit of `gnt` is set.
- **Operand mux.** `mul_a`/`mul_b` = operands of the granted requester. With no grant they are 32'h0, so a zero product is harmlessly computed.
- **Requester rule.**
  - On the cycle after `gnt[i]`, requester i either drops `req[i]` or presents new operands for another operation.
  - Holding `req[i]` high is a new request. Back-to-back issue is allowed, subject to round robin.
- **Tag pipeline.**
  - `LATENCY` stages, each holding {valid, tag}, where tag is $clog2(`NUM_REQ`) bits.
  - Stage 0 loads {grant_any, granted index} and the pipe shifts on each edge where `clk_en` is high.
  - Output stage valid with tag t gives `rsp_valid[t]` = 1 and `rsp_q` = `mul_q`.
  - `rsp_valid` is masked to 0 when `clk_en` is low.
- **Ordering.** Results return in issue order. The block applies no backpressure to responses; requesters must accept `rsp_valid` unconditionally.
- **Arithmetic.** The block never inspects operand values. NaN, Inf and denormals pass through unchanged.

## Timing
- **Reset values.** `ptr` = 0, all pipe valid bits = 0, `gnt` = 0, `rsp_valid` = 0, `idle` = 1 (given `req` = 0).
- **Latency.** A grant in cycle T produces `rsp_valid` in cycle T+`LATENCY`, counted in `clk_en`-high cycles.
- **Throughput.** One operation per enabled cycle, aggregated over all requesters.
- **Stall.** With `clk_en` low for k cycles, `ptr`, the pipe and `fp_mult` hold. The response slips by exactly k cycles and no pulse is lost or duplicated.
- **Simultaneous events.**
  - A new grant and a response to the same requester in the same cycle are both legal and independent.
  - `reset` together with `req` high gives no grant.
- **Reset mid-operation.**
  - All in-flight operations are discarded and no `rsp_valid` pulses afterwards.
  - Requesters must reissue.
  - `mul_q` garbage after reset is ignored because the pipe valid bits are clear.
- **Wrap-around.** `ptr` goes from `NUM_REQ`-1 to 0.

## Test plan
The bench uses a behavioural multiplier with `LATENCY` = 3 and checks one-hot `gnt`/`rsp_valid` every cycle.

- **Single request.** req[1]=1, a=32'h40000000, b=32'h40400000 → gnt[1] in cycle T, rsp_valid[1] in T+3 with rsp_q=32'h40C00000 (2.0×3.0=6.0), then idle=1.
- **Simultaneous requests.** All four req high from reset, each held until granted, each with distinct operands → grants in order 0,1,2,3 on consecutive cycles; rsp_valid pulses 0,1,2,3 on cycles T+3..T+6 with the matching products.
- **Fairness.** req[0] and req[2] held continuously for 8 cycles → grants alternate 0,2,0,2…; no requester waits more than `NUM_REQ`-1 cycles.
- **Stall.** clk_en low for 5 cycles, 1 cycle after a grant → no gnt during the stall; rsp_valid arrives at T+3+5 with the correct product and exactly one pulse.
- **Reset mid-flight.** Reset 1 cycle after two grants → no rsp_valid for the following 10 cycles; ptr=0; the next grant goes to the lowest-index requesting requester.
- **NUM_REQ=2, LATENCY=5.** Both requesters request continuously → grants alternate, and each response arrives exactly 5 cycles after its grant.
